// File: rtl/router_out_rr_arbiter_if.sv
// Handshake bundle between the router input buffers, the output-port arbiter
// and the downstream link. The arbiter connects through the slave modport;
// whatever models the input buffers and the link uses the master modport.
interface router_out_rr_arbiter_if #(
    parameter int N       = 5,
    parameter int W       = 16,
    parameter int CREDITS = 4
);
    localparam int CW = $clog2(CREDITS + 1);

    // Input-buffer side: one request/tail/flit lane per input port
    logic [N-1:0]   req;
    logic [N-1:0]   tail;
    logic [N*W-1:0] in_flit;
    logic [N-1:0]   pop;

    // Downstream link side
    logic           credit_in;
    logic           out_valid;
    logic [W-1:0]   out_flit;

    // Arbitration and credit status
    logic [N-1:0]   gnt;
    logic [CW-1:0]  credit_cnt;
    logic           credit_err;

    modport master (
        output req, tail, in_flit, credit_in,
        input  gnt, pop, out_valid, out_flit, credit_cnt, credit_err
    );

    modport slave (
        input  req, tail, in_flit, credit_in,
        output gnt, pop, out_valid, out_flit, credit_cnt, credit_err
    );
endinterface

// File: rtl/router_out_rr_arbiter.sv
// Wormhole output-port arbiter. N input ports share one output link with
// round-robin priority; a grant is locked from head to tail flit, every flit
// transfer is gated on downstream credits, and the winning flit is registered
// onto the link while the owning input buffer is popped in the same cycle.
// N, W and CREDITS must match the parameters of the connected interface.
module router_out_rr_arbiter #(
    parameter int N       = 5,
    parameter int W       = 16,
    parameter int CREDITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    router_out_rr_arbiter_if.slave   link
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state;
    logic [IW-1:0]  owner;
    logic [IW-1:0]  ptr;
    logic [N-1:0]   gnt_q;
    logic           out_valid_q;
    logic [W-1:0]   out_flit_q;
    logic [CW-1:0]  credit_cnt_q;
    logic           credit_err_q;

    logic           any_req;
    logic [IW-1:0]  winner;
    logic [N-1:0]   win_onehot;
    logic           own_req;
    logic           own_tail;
    logic [W-1:0]   own_flit;
    logic [N-1:0]   own_onehot;
    logic           xfer;

    // Round-robin search: first requester after the last owner, wrapping mod N
    always_comb begin
        logic [IW-1:0] idx;
        any_req = 1'b0;
        winner  = ptr;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!any_req && link.req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    // Select the owner's request/tail/flit lane and build the one-hot vectors
    always_comb begin
        own_req    = 1'b0;
        own_tail   = 1'b0;
        own_flit   = '0;
        own_onehot = '0;
        win_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (owner == IW'(i)) begin
                own_req       = link.req[i];
                own_tail      = link.tail[i];
                own_flit      = link.in_flit[i*W +: W];
                own_onehot[i] = 1'b1;
            end
            if (winner == IW'(i)) begin
                win_onehot[i] = 1'b1;
            end
        end
    end

    // A flit moves only while locked, the owner has data and a credit is free;
    // a reset cycle never consumes a flit because its transfer would be lost.
    assign xfer = (state == LOCKED) && own_req && (credit_cnt_q != '0) && !rst;

    // Grant lock FSM with the registered output flit stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= IW'(N - 1);
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
        end else begin
            out_valid_q <= xfer;
            if (xfer) begin
                out_flit_q <= own_flit;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= LOCKED;
                        owner <= winner;
                        gnt_q <= win_onehot;
                    end
                end
                LOCKED: begin
                    // Only the tail flit releases the link; a stalled owner keeps it
                    if (xfer && own_tail) begin
                        state <= IDLE;
                        gnt_q <= '0;
                        ptr   <= owner;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

    // Downstream credit counter with sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt_q <= CW'(CREDITS);
            credit_err_q <= 1'b0;
        end else begin
            case ({xfer, link.credit_in})
                2'b10: credit_cnt_q <= credit_cnt_q - CW'(1);
                2'b01: begin
                    if (credit_cnt_q == CW'(CREDITS)) begin
                        credit_err_q <= 1'b1;
                    end else begin
                        credit_cnt_q <= credit_cnt_q + CW'(1);
                    end
                end
                default: credit_cnt_q <= credit_cnt_q;
            endcase
        end
    end

    assign link.pop        = xfer ? own_onehot : '0;
    assign link.gnt        = gnt_q;
    assign link.out_valid  = out_valid_q;
    assign link.out_flit   = out_flit_q;
    assign link.credit_cnt = credit_cnt_q;
    assign link.credit_err = credit_err_q;

endmodule
